// File: rtl/micro_pkg.sv
// Shared encodings for the microprogram next-address controller:
// branch uops, sequencer ops and controller FSM states.
package micro_pkg;

    localparam logic [2:0] UOP_CONT  = 3'd0;
    localparam logic [2:0] UOP_JMP   = 3'd1;
    localparam logic [2:0] UOP_JCC   = 3'd2;
    localparam logic [2:0] UOP_CALL  = 3'd3;
    localparam logic [2:0] UOP_CCALL = 3'd4;
    localparam logic [2:0] UOP_RET   = 3'd5;
    localparam logic [2:0] UOP_WAIT  = 3'd6;
    localparam logic [2:0] UOP_DISP  = 3'd7;

    localparam logic [1:0] SEQ_NEXT = 2'd0;
    localparam logic [1:0] SEQ_JUMP = 2'd1;
    localparam logic [1:0] SEQ_CALL = 2'd2;
    localparam logic [1:0] SEQ_RET  = 2'd3;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/micro_cond_mux.sv
// Branch condition select: picks one of eight datapath flags and applies
// the microword polarity bit.
module micro_cond_mux (
    input  logic [7:0] cond,
    input  logic [2:0] sel,
    input  logic       pol,
    output logic       c
);

    assign c = cond[sel] ^ pol;

endmodule

// File: rtl/micro_control.sv
// Next-address controller for the 12-bit microprogram sequencer.
// Define STACK_GUARD_EN to enable stack overflow/underflow substitution and the fault flag.
module micro_control
    import micro_pkg::*;
#(
    parameter int unsigned   AW           = 12,
    parameter logic [AW-1:0] RESET_VECTOR = AW'(12'h000),
    parameter logic [AW-1:0] IRQ_VECTOR   = AW'(12'h010),
    parameter logic [AW-1:0] FAULT_VECTOR = AW'(12'h020),
    parameter int unsigned   STACK_DEPTH  = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [2:0]    mw_uop,
    input  logic [2:0]    mw_cond_sel,
    input  logic          mw_cond_pol,
    input  logic [AW-1:0] mw_addr,
    input  logic [3:0]    disp_idx,
    input  logic [AW-1:0] upc,
    input  logic [7:0]    cond,
    input  logic          stall,
    input  logic          irq,
    output logic          irq_ack,
    output logic [1:0]    seq_op,
    output logic [AW-1:0] seq_din,
    output logic [AW-1:0] seq_offset,
    output logic [2:0]    depth,
    output logic          fault,
    input  logic          fault_clr
);

    state_t     state_q, state_d;
    logic [2:0] depth_q, depth_d;
    logic       c;

    micro_cond_mux u_cond_mux (
        .cond (cond),
        .sel  (mw_cond_sel),
        .pol  (mw_cond_pol),
        .c    (c)
    );

`ifdef STACK_GUARD_EN
    logic fault_q;
    logic fault_set;
`else
    logic unused_guard;
    assign unused_guard = ^{fault_clr, FAULT_VECTOR, STACK_DEPTH[2:0]};
`endif

    always_comb begin
        seq_op     = SEQ_NEXT;
        seq_din    = '0;
        seq_offset = '0;
        irq_ack    = 1'b0;
        state_d    = state_q;
        depth_d    = depth_q;
`ifdef STACK_GUARD_EN
        fault_set  = 1'b0;
`endif
        unique case (state_q)
            BOOT: begin
                seq_op  = SEQ_JUMP;
                seq_din = RESET_VECTOR;
                state_d = stall ? HOLD : RUN;
            end
            RUN, HOLD: begin
                if (stall) begin
                    // Refetch the word in the pipeline register until stall drops.
                    seq_op  = SEQ_JUMP;
                    seq_din = upc;
                    state_d = HOLD;
                end else begin
                    state_d = RUN;
                    case (mw_uop)
                        UOP_CONT:  seq_op = SEQ_NEXT;
                        UOP_JMP:   begin seq_op = SEQ_JUMP; seq_din = mw_addr; end
                        UOP_JCC:   if (c) begin seq_op = SEQ_JUMP; seq_din = mw_addr; end
                        UOP_CALL:  begin seq_op = SEQ_CALL; seq_din = mw_addr; end
                        UOP_CCALL: if (c) begin seq_op = SEQ_CALL; seq_din = mw_addr; end
                        UOP_RET:   seq_op = SEQ_RET;
                        UOP_WAIT:  if (!c) begin seq_op = SEQ_JUMP; seq_din = upc; end
                        UOP_DISP:  begin
                            seq_op     = SEQ_JUMP;
                            seq_din    = mw_addr;
                            seq_offset = AW'(disp_idx);
                        end
                    endcase
                    if (state_q == RUN && irq && mw_uop == UOP_CONT) begin
                        seq_op  = SEQ_CALL;
                        seq_din = IRQ_VECTOR;
                        irq_ack = 1'b1;
                    end
`ifdef STACK_GUARD_EN
                    if ((seq_op == SEQ_CALL && depth_q == STACK_DEPTH[2:0]) ||
                        (seq_op == SEQ_RET && depth_q == 3'd0)) begin
                        seq_op     = SEQ_JUMP;
                        seq_din    = FAULT_VECTOR;
                        seq_offset = '0;
                        irq_ack    = 1'b0;
                        depth_d    = '0;
                        fault_set  = 1'b1;
                    end else
`endif
                    if (seq_op == SEQ_CALL) begin
                        depth_d = depth_q + 3'd1;
                    end else if (seq_op == SEQ_RET) begin
                        depth_d = depth_q - 3'd1;
                    end
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            depth_q <= '0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
        end
    end

`ifdef STACK_GUARD_EN
    // A fault raised this cycle outranks a simultaneous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else if (fault_set) begin
            fault_q <= 1'b1;
        end else if (fault_clr) begin
            fault_q <= 1'b0;
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    assign depth = depth_q;

endmodule

// File: tb/tb_micro_control.sv
// Scoreboard bench for micro_control: directed scenarios then random traffic,
// checked against a behavioural model of the next-address rules.
module tb_micro_control;

    localparam logic [11:0] RV  = 12'h000;
    localparam logic [11:0] IV  = 12'h010;
    localparam logic [11:0] FV  = 12'h020;
    localparam int          SD  = 4;

    logic        clock, reset;
    logic [2:0]  mw_uop, mw_cond_sel;
    logic        mw_cond_pol;
    logic [11:0] mw_addr, upc;
    logic [3:0]  disp_idx;
    logic [7:0]  cond;
    logic        stall, irq, fault_clr;
    logic        irq_ack, fault;
    logic [1:0]  seq_op;
    logic [11:0] seq_din, seq_offset;
    logic [2:0]  depth;

    micro_control dut (
        .clock       (clock),
        .reset       (reset),
        .mw_uop      (mw_uop),
        .mw_cond_sel (mw_cond_sel),
        .mw_cond_pol (mw_cond_pol),
        .mw_addr     (mw_addr),
        .disp_idx    (disp_idx),
        .upc         (upc),
        .cond        (cond),
        .stall       (stall),
        .irq         (irq),
        .irq_ack     (irq_ack),
        .seq_op      (seq_op),
        .seq_din     (seq_din),
        .seq_offset  (seq_offset),
        .depth       (depth),
        .fault       (fault),
        .fault_clr   (fault_clr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int op;
        int din;
        int off;
        int ack;
        int dep;
        int flt;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Model state: stack depth, fault flag, first cycle after reset, just left a stall.
    int m_depth = 0;
    bit m_fault = 0;
    bit m_boot  = 1;
    bit m_held  = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("seq_op", int'(seq_op), e.op);
            chk("seq_din", int'(seq_din), e.din);
            chk("seq_offset", int'(seq_offset), e.off);
            chk("irq_ack", int'(irq_ack), e.ack);
            chk("depth", int'(depth), e.dep);
            chk("fault", int'(fault), e.flt);
        end
    end

    // Apply current inputs for one cycle: predict outputs, queue them, advance the model.
    task automatic step();
        exp_t e;
        int   nd;
        bit   nf, nh, c, newf;
        e = '{op: 0, din: 0, off: 0, ack: 0, dep: m_depth, flt: m_fault};
        nd = m_depth; nf = m_fault; nh = m_held; newf = 0;
        if (m_boot || reset) begin
            e.op = 1; e.din = int'(RV);
            nh = stall;
        end else if (stall) begin
            e.op = 1; e.din = int'(upc);
            nh = 1;
        end else begin
            c = cond[mw_cond_sel] ^ mw_cond_pol;
            case (mw_uop)
                3'd1: begin e.op = 1; e.din = int'(mw_addr); end
                3'd2: if (c) begin e.op = 1; e.din = int'(mw_addr); end
                3'd3: begin e.op = 2; e.din = int'(mw_addr); end
                3'd4: if (c) begin e.op = 2; e.din = int'(mw_addr); end
                3'd5: e.op = 3;
                3'd6: if (!c) begin e.op = 1; e.din = int'(upc); end
                3'd7: begin e.op = 1; e.din = int'(mw_addr); e.off = int'(disp_idx); end
                default: e.op = 0;
            endcase
            if (!m_held && irq && mw_uop == 3'd0) begin
                e.op = 2; e.din = int'(IV); e.ack = 1;
            end
`ifdef STACK_GUARD_EN
            if ((e.op == 2 && m_depth == SD) || (e.op == 3 && m_depth == 0)) begin
                e.op = 1; e.din = int'(FV); e.off = 0; e.ack = 0;
                nd = 0; newf = 1;
            end else
`endif
            if (e.op == 2) nd = (m_depth + 1) % 8;
            else if (e.op == 3) nd = (m_depth + 7) % 8;
            nh = 0;
        end
`ifdef STACK_GUARD_EN
        if (newf) nf = 1;
        else if (fault_clr) nf = 0;
`else
        nf = 0;
`endif
        if (reset) begin
            e.dep = 0; e.flt = 0;
            nd = 0; nf = 0; nh = 0;
        end
        sbq.push_back(e);
        @(posedge clock);
        #1;
        m_boot  = reset;
        m_depth = nd;
        m_fault = nf;
        m_held  = nh;
    endtask

    task automatic set_mw(input logic [2:0] u, input logic [2:0] s, input logic p,
                          input logic [11:0] a);
        mw_uop = u; mw_cond_sel = s; mw_cond_pol = p; mw_addr = a;
    endtask

    initial begin
        reset = 1; stall = 0; irq = 0; fault_clr = 0; cond = '0; upc = '0; disp_idx = '0;
        set_mw(3'd0, 3'd0, 1'b0, 12'h000);
        @(posedge clock);
        #1;
        step();
        reset = 0;
        step();                                   // BOOT vector
        step();                                   // CONT in RUN
        cond = 8'h08;
        set_mw(3'd2, 3'd3, 1'b0, 12'h123); step();
        set_mw(3'd2, 3'd3, 1'b1, 12'h123); step();
        disp_idx = 4'd5;
        set_mw(3'd7, 3'd0, 1'b0, 12'h200); step();
        upc = 12'h055;
        set_mw(3'd3, 3'd0, 1'b0, 12'h300);
        stall = 1; repeat (3) step();
        stall = 0; step();
        irq = 1;
        set_mw(3'd0, 3'd0, 1'b0, 12'h000); step();
        set_mw(3'd1, 3'd0, 1'b0, 12'h0ab); step();
        irq = 0;
        reset = 1; step(); reset = 0; step();
        set_mw(3'd3, 3'd0, 1'b0, 12'h400); repeat (5) step();
        set_mw(3'd5, 3'd0, 1'b0, 12'h000); step(); step();
        fault_clr = 1; set_mw(3'd0, 3'd0, 1'b0, 12'h000); step();
        fault_clr = 0; step();
        for (int i = 0; i < 3000; i++) begin
            set_mw(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   12'($urandom));
            disp_idx  = 4'($urandom);
            upc       = 12'($urandom);
            cond      = 8'($urandom);
            stall     = ($urandom_range(0, 99) < 20);
            irq       = ($urandom_range(0, 99) < 25);
            fault_clr = ($urandom_range(0, 99) < 10);
            reset     = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 0;
        stall = 0;
        @(negedge clock);
        #1;
        n_checks++;
        if (sbq.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/micro_control.md
Name: micro_control

Overview:
- Next-address controller for the 12-bit microprogram sequencer (2-bit op, din, offset, yout).
- Decodes branch fields of the microword in the pipeline register and evaluates a selected condition.
- Produces sequencer op/din/offset every cycle.
- Adds stall hold, interrupt entry, boot vectoring, and a 4-deep stack guard, because the sequencer's stack pointer wraps silently.

Parameters:
AW, 12, micro-address width; must match sequencer.
RESET_VECTOR, 12'h000, first micro-address fetched after reset.
IRQ_VECTOR, 12'h010, microroutine called on interrupt entry.
FAULT_VECTOR, 12'h020, micro-address jumped to on stack overflow/underflow.
STACK_DEPTH, 4, sequencer stack entries.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
mw_uop  in  3  branch type (see Behaviour)
mw_cond_sel  in  3  selects cond[mw_cond_sel]
mw_cond_pol  in  1  1 = branch when condition false
mw_addr  in  AW  branch target
disp_idx  in  4  dispatch index for DISP
upc  in  AW  address of microword now in pipeline register
cond  in  8  datapath condition flags
stall  in  1  freeze microprogram
irq  in  1  interrupt request, level
irq_ack  out  1  one-cycle pulse on interrupt entry
seq_op  out  2  0 next, 1 jump, 2 call, 3 return
seq_din  out  AW  sequencer din
seq_offset  out  AW  sequencer offset
depth  out  3  tracked stack depth
fault  out  1  sticky stack fault
fault_clr  in  1  clears fault

Behaviour:
- Outputs seq_* and irq_ack are combinational from state + inputs; depth, fault, and FSM state are registered.
- Defaults: seq_op=0, seq_din=0, seq_offset=0.
- Reset values: state=BOOT, depth=0, fault=0, irq_ack=0.
- Condition evaluation: c = cond[mw_cond_sel] XOR mw_cond_pol.
- uop decode in RUN:
  - 0 CONT: op 0.
  - 1 JMP: op 1, din=mw_addr.
  - 2 JCC: c ? (op 1, din=mw_addr) : op 0.
  - 3 CALL: op 2, din=mw_addr.
  - 4 CCALL: c ? (op 2, din=mw_addr) : op 0.
  - 5 RET: op 3.
  - 6 WAIT: c ? op 0 : (op 1, din=upc).
  - 7 DISP: op 1, din=mw_addr, offset={8'b0,disp_idx}.
  - Arithmetic: target = din + offset modulo 2^AW; no carry out.
- FSM states:
  - BOOT (one cycle): op 1, din=RESET_VECTOR, then RUN.
  - RUN: normal decode as above.
  - HOLD: entered while stall=1. Output is op 1, din=upc, offset 0, so the same word is refetched; depth is unchanged. Return to RUN the cycle after stall falls.
- Stall priority and interaction:
  - stall has priority over irq and all uops.
  - Stall is sampled in RUN and BOOT; BOOT completes first.
- Interrupt entry:
  - Taken only in RUN, when irq=1, stall=0, and uop is CONT.
  - Output op 2, din=IRQ_VECTOR; irq_ack=1 for that cycle; depth+1.
  - irq is not latched; a source must hold it until irq_ack.
- Depth tracking (per cycle without stall):
  - Effective op 2: depth+1.
  - Effective op 3: depth-1.
- Overflow (STACK_GUARD_EN): effective call with depth==STACK_DEPTH.
  - Output is replaced by op 1, din=FAULT_VECTOR.
  - fault<=1; depth<=0; no irq_ack.
- Underflow (STACK_GUARD_EN): return with depth==0. Handled identically to overflow.
- fault:
  - Cleared by fault_clr=1 on any cycle.
  - A simultaneous new fault wins, so fault stays 1.
- Reset mid-operation: asynchronous return to BOOT; the sequencer is reset in parallel.

Optional Feature:
STACK_GUARD_EN
- Defined: overflow/underflow substitution and the fault flag as above.
- Undefined: depth counts modulo 8 for debug only, no substitution, fault tied 0, and fault_clr ignored.

Decomposition:
- Package micro_pkg holds:
  - uop encodings (UOP_CONT..UOP_DISP).
  - Sequencer op encodings (SEQ_NEXT, SEQ_JUMP, SEQ_CALL, SEQ_RET).
  - FSM state typedef (BOOT, RUN, HOLD).
- One natural sub-module, micro_cond_mux: 8:1 condition select plus polarity XOR.

Test Plan:
- Reset release -> first cycle op=1, din=12'h000; next cycle RUN with CONT gives op=0.
- JCC with cond_sel=3, cond=8'h08, pol=0, addr=12'h123 -> op=1, din=12'h123. Same with pol=1 -> op=0.
- DISP with addr=12'h200, disp_idx=5 -> op=1, din=12'h200, offset=12'h005.
- stall held for 3 cycles during CALL -> three cycles of op=1, din=upc, depth unchanged. Release gives op=2 and depth 1.
- irq=1 during CONT -> op=2, din=12'h010, irq_ack for 1 cycle, depth+1. irq during JMP -> no ack.
- (STACK_GUARD_EN) five CALLs -> fifth gives op=1, din=12'h020, fault=1, depth=0. RET at depth 0 also faults. fault_clr clears fault.
